// File: rtl/mod3_pkg.sv
// Shared types and constants for the mod-3 serial link.
// Residue encodings line up with the receiver's s0/s1/s2 states.
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAD   = 2'b10
    } tx_state_t;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    // Two trailer bits that bring a residue back to zero: 4*v + t == 0 (mod 3).
    function automatic logic [1:0] trailer_of(input logic [1:0] r);
        logic [1:0] t;
        case (r)
            R1:      t = 2'd2;
            R2:      t = 2'd1;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mod3_residue_step.sv
// One step of the MSB-first residue recurrence: res_out = (2*res_in + data_bit) mod 3.
// The unreachable code 3 is folded onto R0.
module mod3_residue_step
    import mod3_pkg::*;
(
    input  logic [1:0] res_in,
    input  logic       data_bit,
    output logic [1:0] res_out
);

    always_comb begin
        res_out = R0;
        case (res_in)
            R1:      res_out = data_bit ? R0 : R2;
            R2:      res_out = data_bit ? R2 : R1;
            default: res_out = data_bit ? R1 : R0;
        endcase
    end

endmodule

// File: rtl/mod3_stream_tx.sv
// Parallel-to-serial transmitter (MSB first) with a running residue mod 3.
// Define MOD3_PAD_EN to append a 2-bit trailer that makes every frame divisible by 3.
module mod3_stream_tx
    import mod3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             sof,
    output logic             eof,
    output logic [1:0]       res
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef MOD3_PAD_EN
    localparam int LAST = WIDTH + 1;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT  = CW'(LAST);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic [1:0]       res_next;
    logic             last_bit;
    logic             accept;

    assign out_valid = (state != IDLE);
    assign out       = out_valid & sr[WIDTH-1];
    assign sof       = (state == SHIFT) && (cnt == '0);
    assign last_bit  = out_valid && (cnt == LAST_CNT);
    assign eof       = last_bit;
    assign din_ready = !rst && ((state == IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    mod3_residue_step u_step (
        .res_in   (res),
        .data_bit (out),
        .res_out  (res_next)
    );

    // The trailer rides out of the top of the shift register once the data is gone.
    always_comb begin
        sr_next = {sr[WIDTH-2:0], 1'b0};
`ifdef MOD3_PAD_EN
        if ((state == SHIFT) && (cnt == DATA_LAST)) begin
            sr_next = '0;
            sr_next[WIDTH-1 -: 2] = trailer_of(res_next);
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = IDLE;
            SHIFT: begin
                if (cnt == DATA_LAST) begin
`ifdef MOD3_PAD_EN
                    state_next = PAD;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef MOD3_PAD_EN
            PAD: begin
                if (cnt == LAST_CNT) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (accept) begin
            state_next = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            res   <= R0;
        end else begin
            state <= state_next;
            if (accept) begin
                sr  <= din;
                cnt <= '0;
                res <= R0;
            end else if (out_valid) begin
                sr  <= sr_next;
                cnt <= cnt + CW'(1);
                res <= res_next;
            end
        end
    end

endmodule

// File: tb/tb_mod3_stream_tx.sv
// Self-checking bench for mod3_stream_tx (WIDTH=8), valid with or without MOD3_PAD_EN.
// A queue-based frame model scores every cycle; directed sequences cover the corner cases.
module tb_mod3_stream_tx;

    localparam int WIDTH = 8;
`ifdef MOD3_PAD_EN
    localparam bit PAD_ON    = 1'b1;
    localparam int FRAME_LEN = WIDTH + 2;
`else
    localparam bit PAD_ON    = 1'b0;
    localparam int FRAME_LEN = WIDTH;
`endif

    typedef struct {
        logic [7:0] din;
        logic [1:0] trail;
        logic [1:0] raw_res;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             out;
    logic             out_valid;
    logic             sof;
    logic             eof;
    logic [1:0]       res;

    int checks   = 0;
    int failures = 0;

    int     exp_q[$];
    int     exp_pos;
    longint prefix_val;
    longint cur_frame;
    longint frames_done[$];
    bit     mon_en = 1'b0;
    bit     m_valid;
    bit     m_ready;

    vec_t vecs[$];

    mod3_stream_tx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out       (out),
        .out_valid (out_valid),
        .sof       (sof),
        .eof       (eof),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame = data bits MSB first, then t[1], t[0] where t makes 4*din+t divisible by 3.
    function automatic void buildFrame(input logic [7:0] d);
        int t;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(d[i]));
        if (PAD_ON) begin
            t = (3 - (int'(d) % 3)) % 3;
            exp_q.push_back(t / 2);
            exp_q.push_back(t % 2);
        end
    endfunction

    function automatic longint frameValue(input vec_t v);
        if (PAD_ON) return longint'(v.din) * 4 + longint'(v.trail);
        return longint'(v.din);
    endfunction

    function automatic int finalRes(input vec_t v);
        if (PAD_ON) return 0;
        return int'(v.raw_res);
    endfunction

    // Cycle scoreboard: compare, then advance the model with the inputs seen by the next edge.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            m_valid = (exp_q.size() > 0);
            m_ready = !rst && (exp_q.size() <= 1);
            checkOutput("mon_out_valid", out_valid, m_valid);
            if (m_valid) checkOutput("mon_out", out, exp_q[0]);
            else         checkOutput("mon_out_idle", out, 0);
            checkOutput("mon_sof", sof, m_valid && (exp_pos == 0));
            checkOutput("mon_eof", eof, exp_q.size() == 1);
            checkOutput("mon_res", res, prefix_val % 3);
            checkOutput("mon_din_ready", din_ready, m_ready);
            if (rst) begin
                exp_q.delete();
                prefix_val = 0;
                exp_pos    = 0;
                cur_frame  = 0;
            end else begin
                if (m_valid) begin
                    cur_frame  = cur_frame * 2 + longint'(out);
                    prefix_val = prefix_val * 2 + exp_q[0];
                    if (exp_q.size() == 1) begin
                        frames_done.push_back(cur_frame);
                        cur_frame = 0;
                    end
                    void'(exp_q.pop_front());
                    exp_pos++;
                end
                if (din_valid && m_ready) begin
                    buildFrame(din);
                    prefix_val = 0;
                    exp_pos    = 0;
                    cur_frame  = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        int   n;
        logic rdy;
        n   = 0;
        rdy = 1'b0;
        @(negedge clk); #1;
        din       = d;
        din_valid = 1'b1;
        while (!rdy && n < 40) begin
            #1 rdy = din_ready;
            @(posedge clk);
            if (!rdy) begin
                @(negedge clk); #1;
            end
            n++;
        end
        checkOutput("accept_in_time", rdy, 1);
        @(negedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic waitFrame(input string name, input longint exp_val, input bit check_idle, input int exp_res);
        int n;
        n = 0;
        while (frames_done.size() == 0 && n < 4 * FRAME_LEN) begin
            @(negedge clk); #3;
            n++;
        end
        checkOutput({name, "_done"}, frames_done.size() > 0, 1);
        if (frames_done.size() > 0) checkOutput({name, "_bits"}, frames_done.pop_front(), exp_val);
        if (check_idle) begin
            @(negedge clk); #3;
            checkOutput({name, "_idle_valid"}, out_valid, 0);
            checkOutput({name, "_final_res"}, res, exp_res);
        end
    endtask

    initial begin
        int k;
        int accepts;
        vecs.push_back('{8'h06, 2'd0, 2'd0});
        vecs.push_back('{8'h07, 2'd2, 2'd1});
        vecs.push_back('{8'h80, 2'd1, 2'd2});
        vecs.push_back('{8'h01, 2'd2, 2'd1});
        vecs.push_back('{8'h55, 2'd2, 2'd1});
        vecs.push_back('{8'hAA, 2'd1, 2'd2});
        vecs.push_back('{8'hFF, 2'd0, 2'd0});
        vecs.push_back('{8'h05, 2'd1, 2'd2});
        vecs.push_back('{8'hA5, 2'd0, 2'd0});
        vecs.push_back('{8'h03, 2'd0, 2'd0});

        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        exp_pos    = 0;
        prefix_val = 0;
        cur_frame  = 0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Reset together with a valid word: nothing may be taken.
        @(negedge clk); #1;
        din       = 8'h06;
        din_valid = 1'b1;
        #1;
        checkOutput("rst_din_ready", din_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_res", res, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("rstv_no_accept", out_valid, 0);
        checkOutput("rstv_ready_after", din_ready, 1);
        @(posedge clk);
        @(negedge clk); #1;
        din_valid = 1'b0;
        #1;
        checkOutput("rstv_sof_next", sof, 1);
        waitFrame("rstv_frame", frameValue(vecs[0]), 1'b1, finalRes(vecs[0]));

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            frames_done.delete();
            applyStimulus(vecs[i].din);
            waitFrame($sformatf("vec%0d", i), frameValue(vecs[i]), 1'b1, finalRes(vecs[i]));
        end

        // Back-to-back 05 then FF with the second accept on the eof cycle.
        frames_done.delete();
        applyStimulus(vecs[7].din);
        din       = vecs[6].din;
        din_valid = 1'b1;
        k = 0;
        #1;
        while (!din_ready && k < 4 * FRAME_LEN) begin
            @(negedge clk); #2;
            k++;
        end
        checkOutput("b2b_ready_wait", k, FRAME_LEN - 1);
        checkOutput("b2b_ready_on_eof", eof, 1);
        @(posedge clk);
        @(negedge clk); #1;
        din_valid = 1'b0;
        #1;
        checkOutput("b2b_sof_no_gap", sof, 1);
        waitFrame("b2b_first", frameValue(vecs[7]), 1'b0, 0);
        waitFrame("b2b_second", frameValue(vecs[6]), 1'b1, finalRes(vecs[6]));

        // din_valid held high: one accept per frame, sof every FRAME_LEN cycles.
        @(negedge clk); #1;
        din       = 8'($urandom);
        din_valid = 1'b1;
        k = 0;
        #1;
        while (!sof && k < 20) begin
            @(negedge clk); #1;
            din = 8'($urandom);
            #1;
            k++;
        end
        checkOutput("hold_first_sof", sof, 1);
        accepts = 0;
        for (int j = 0; j < 3 * FRAME_LEN; j++) begin
            if (j > 0) begin
                @(negedge clk); #1;
                din = 8'($urandom);
                #1;
            end
            checkOutput("hold_sof", sof, (j % FRAME_LEN) == 0);
            if (din_ready && din_valid) accepts++;
        end
        checkOutput("hold_accepts", accepts, 3);
        @(negedge clk); #1;
        din_valid = 1'b0;
        repeat (2 * FRAME_LEN) @(posedge clk);

        // Reset on bit 3 of A5 aborts the frame; 03 then goes out intact.
        frames_done.delete();
        applyStimulus(vecs[8].din);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_res", res, 0);
        checkOutput("abort_eof", eof, 0);
        repeat (FRAME_LEN) @(posedge clk);
        checkOutput("abort_no_frame", frames_done.size(), 0);
        applyStimulus(vecs[9].din);
        waitFrame("after_abort", frameValue(vecs[9]), 1'b1, finalRes(vecs[9]));

        // Random traffic with occasional resets, scored by the model.
        for (int j = 0; j < 600; j++) begin
            @(negedge clk); #1;
            din_valid = 1'($urandom_range(0, 1));
            din       = 8'($urandom);
            rst       = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk); #1;
        rst       = 1'b0;
        din_valid = 1'b0;
        repeat (2 * FRAME_LEN) @(posedge clk);
        @(negedge clk); #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
